// File: rtl/unidad_control_alu.sv
// Two-state sequencer around the external 4-bit ALU: accept instruction, read operands
// from a 4x4 register bank, then retire the ALU result (or an immediate) back to the bank.
module unidad_control_alu #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iInstrValid,
    input  logic [13:0]       ivInstr,
    output logic              oReady,
    output logic [3:0]        ovAluInstruccion,
    output logic [DATA_W-1:0] ovAluRegA,
    output logic [DATA_W-1:0] ovAluRegB,
    input  logic [DATA_W-1:0] ivAluResultado,
    input  logic [3:0]        ivAluFlags,
    output logic [3:0]        ovFlags,
    output logic [DATA_W-1:0] ovResultado,
    output logic              oDone,
    output logic              oError,
    input  logic [1:0]        ivRdAddr,
    output logic [DATA_W-1:0] ovRdData
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [3:0] OP_LAST_ALU = 4'b1010;
    localparam logic [3:0] OP_LOADI    = 4'b1111;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [1:0]        r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_flags;
    logic [DATA_W-1:0] r_resultado;
    logic              r_done;
    logic              r_error;

    logic [3:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_ra;
    logic [1:0]        w_rb;
    logic [DATA_W-1:0] w_imm;

    assign w_op  = ivInstr[13:10];
    assign w_rd  = ivInstr[9:8];
    assign w_ra  = ivInstr[7:6];
    assign w_rb  = ivInstr[5:4];
    assign w_imm = ivInstr[3:0];

    // The opcode register doubles as the captured opcode acted on in EXEC.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_imm       <= '0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_flags     <= '0;
            r_resultado <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iInstrValid) begin
                        r_alu_op <= w_op;
                        r_alu_a  <= r_regs[w_ra];
                        r_alu_b  <= r_regs[w_rb];
                        r_rd     <= w_rd;
                        r_imm    <= w_imm;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_alu_op <= OP_LAST_ALU) begin
                        r_regs[r_rd] <= ivAluResultado;
                        r_resultado  <= ivAluResultado;
                        r_flags      <= ivAluFlags;
                    end else if (r_alu_op == OP_LOADI) begin
                        r_regs[r_rd] <= r_imm;
                        r_resultado  <= r_imm;
                    end else begin
                        r_error <= 1'b1;
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oReady           = (r_state == IDLE);
    assign ovAluInstruccion = r_alu_op;
    assign ovAluRegA        = r_alu_a;
    assign ovAluRegB        = r_alu_b;
    assign ovFlags          = r_flags;
    assign ovResultado      = r_resultado;
    assign oDone            = r_done;
    assign oError           = r_error;
    assign ovRdData         = r_regs[ivRdAddr];

endmodule

// File: tb/tb_unidad_control_alu.sv
// Bench for unidad_control_alu: behavioural ALU stub, reference model of the register
// bank/status, and a scoreboard monitor that checks operands in EXEC and results on oDone.
module tb_unidad_control_alu;

    logic        iClk = 1'b0;
    logic        iReset = 1'b1;
    logic        iInstrValid = 1'b0;
    logic [13:0] ivInstr = '0;
    logic        oReady;
    logic [3:0]  ovAluInstruccion;
    logic [3:0]  ovAluRegA;
    logic [3:0]  ovAluRegB;
    logic [3:0]  ivAluResultado;
    logic [3:0]  ivAluFlags;
    logic [3:0]  ovFlags;
    logic [3:0]  ovResultado;
    logic        oDone;
    logic        oError;
    logic [1:0]  ivRdAddr = '0;
    logic [3:0]  ovRdData;

    unidad_control_alu dut (
        .iClk             (iClk),
        .iReset           (iReset),
        .iInstrValid      (iInstrValid),
        .ivInstr          (ivInstr),
        .oReady           (oReady),
        .ovAluInstruccion (ovAluInstruccion),
        .ovAluRegA        (ovAluRegA),
        .ovAluRegB        (ovAluRegB),
        .ivAluResultado   (ivAluResultado),
        .ivAluFlags       (ivAluFlags),
        .ovFlags          (ovFlags),
        .ovResultado      (ovResultado),
        .oDone            (oDone),
        .oError           (oError),
        .ivRdAddr         (ivRdAddr),
        .ovRdData         (ovRdData)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 iClk = ~iClk;
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // ---------------- ALU stub: returns {Z,N,C,V, result} ----------------
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int          s;
        logic [3:0]  r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = int'(a) + int'(b);
                r = 4'(s);
                c = (s > 15);
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                r = 4'(int'(a) - int'(b));
                c = (a < b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a & b);
            4'd6: r = ~(a | b);
            4'd7: r = ~(a ^ b);
            4'd8: r = ~a;
            4'd9: begin r = {a[2:0], 1'b0}; c = a[3]; end
            4'd10: begin r = {1'b0, a[3:1]}; c = a[0]; end
            default: r = 4'd0;
        endcase
        return {(r == 4'd0), r[3], c, v, r};
    endfunction

    always_comb {ivAluFlags, ivAluResultado} = alu_f(ovAluInstruccion, ovAluRegA, ovAluRegB);

    // ---------------- reference model and scoreboard ----------------
    logic [3:0]  m_regs [4];
    logic [3:0]  m_res;
    logic [3:0]  m_flags;
    logic [11:0] exp_alu_q[$];   // {op, a, b} expected during EXEC
    logic [8:0]  exp_q[$];       // {error, resultado, flags} expected at oDone

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
        m_res   = 4'd0;
        m_flags = 4'd0;
    endtask

    // Apply one instruction to the model at acceptance time.
    task automatic model_accept(input logic [13:0] ins, input bit retire);
        logic [3:0] op, imm, a, b;
        logic [1:0] rd;
        logic [7:0] fr;
        logic       err;
        op  = ins[13:10];
        rd  = ins[9:8];
        imm = ins[3:0];
        a   = m_regs[ins[7:6]];
        b   = m_regs[ins[5:4]];
        exp_alu_q.push_back({op, a, b});
        if (!retire) return;
        err = 1'b0;
        if (op <= 4'd10) begin
            fr         = alu_f(op, a, b);
            m_regs[rd] = fr[3:0];
            m_res      = fr[3:0];
            m_flags    = fr[7:4];
        end else if (op == 4'd15) begin
            m_regs[rd] = imm;
            m_res      = imm;
        end else begin
            err = 1'b1;
        end
        exp_q.push_back({err, m_res, m_flags});
    endtask

    // Monitor: operands while busy, results whenever oDone fires.
    always @(negedge iClk) begin
        logic [11:0] ea;
        logic [8:0]  er;
        if (oReady === 1'b0) begin
            if (exp_alu_q.size() == 0) begin
                chk("alu_unexpected_exec", 16'd1, 16'd0);
            end else begin
                ea = exp_alu_q.pop_front();
                chk("alu_operands", {4'd0, ovAluInstruccion, ovAluRegA, ovAluRegB}, {4'd0, ea});
            end
        end
        if (oError === 1'b1 && oDone !== 1'b1) chk("error_without_done", 16'd1, 16'd0);
        if (oDone === 1'b1) begin
            done_cnt++;
            if (oReady !== 1'b1) chk("ready_with_done", {15'd0, oReady}, 16'd1);
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 16'd1, 16'd0);
            end else begin
                er = exp_q.pop_front();
                chk("retire_err_res_flags", {7'd0, oError, ovResultado, ovFlags}, {7'd0, er});
            end
        end
    end

    // ---------------- driver tasks ----------------
    int last_acc = 0;

    // Present an instruction and wait for its handshake; leaves iInstrValid high.
    task automatic issue(input logic [13:0] ins, input bit retire);
        int guard;
        @(negedge iClk);
        iInstrValid = 1'b1;
        ivInstr     = ins;
        guard       = 0;
        while (oReady !== 1'b1 && guard < 20) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 20) begin
            chk("issue_timeout", 16'd1, 16'd0);
        end else begin
            last_acc = cyc;
            model_accept(ins, retire);
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic go_idle(input int n);
        iInstrValid = 1'b0;
        repeat (n) @(negedge iClk);
    endtask

    task automatic wait_retired();
        int guard;
        iInstrValid = 1'b0;
        guard = 0;
        do begin
            @(negedge iClk);
            #2;
            guard++;
        end while ((exp_q.size() != 0 || oReady !== 1'b1) && guard < 20);
        if (guard >= 20) chk("retire_timeout", 16'd1, 16'd0);
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            ivRdAddr = 2'(i);
            #1;
            chk({tag, "_reg"}, {12'd0, ovRdData}, {12'd0, m_regs[i]});
        end
        chk({tag, "_res"}, {12'd0, ovResultado}, {12'd0, m_res});
        chk({tag, "_flags"}, {12'd0, ovFlags}, {12'd0, m_flags});
    endtask

    function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int d0, d1;
        logic [3:0] imms [4];
        model_reset();
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset = 1'b0;
        #1;
        chk("reset_ready", {15'd0, oReady}, 16'd1);
        chk("reset_done", {14'd0, oDone, oError}, 16'd0);
        chk("reset_alu", {4'd0, ovAluInstruccion, ovAluRegA, ovAluRegB}, 16'd0);
        check_state("reset");

        // Load then add
        issue(mk(4'hF, 2'd1, 2'd0, 2'd0, 4'd5), 1'b1);
        issue(mk(4'hF, 2'd2, 2'd0, 2'd0, 4'd3), 1'b1);
        issue(mk(4'h0, 2'd0, 2'd1, 2'd2, 4'd0), 1'b1);
        wait_retired();
        chk("add_result", {12'd0, ovResultado}, 16'd8);
        chk("add_flags", {12'd0, ovFlags}, 16'b0101);
        check_state("add");

        // Subtract
        issue(mk(4'h1, 2'd3, 2'd2, 2'd1, 4'd0), 1'b1);
        wait_retired();
        ivRdAddr = 2'd3;
        #1;
        chk("sub_reg3", {12'd0, ovRdData}, 16'b1110);
        chk("sub_flags", {12'd0, ovFlags}, 16'b0110);

        // Throughput: valid held high across four LOADIs
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            imms[i] = 4'($urandom_range(0, 15));
            issue(mk(4'hF, 2'(i), 2'(i), 2'(i), imms[i]), 1'b1);
            d1 = last_acc;
            if (i > 0) chk("throughput_spacing", 16'(d1 - d0), 16'd2);
            d0 = d1;
        end
        d0 = done_cnt;
        wait_retired();
        for (int i = 0; i < 4; i++) begin
            ivRdAddr = 2'(i);
            #1;
            chk("burst_reg", {12'd0, ovRdData}, {12'd0, imms[i]});
        end

        // Illegal opcode
        issue(mk(4'b1100, 2'd0, 2'd1, 2'd2, 4'd9), 1'b1);
        wait_retired();
        check_state("illegal");

        // Reset mid-op: ADD accepted, reset during its EXEC cycle
        d0 = done_cnt;
        issue(mk(4'h0, 2'd0, 2'd1, 2'd2, 4'd0), 1'b0);
        iInstrValid = 1'b0;
        iReset = 1'b1;
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        model_reset();
        repeat (3) @(negedge iClk);
        #1;
        chk("midop_no_done", 16'(done_cnt - d0), 16'd0);
        chk("midop_ready", {15'd0, oReady}, 16'd1);
        check_state("midop");

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            issue(14'($urandom_range(0, 16383)), 1'b1);
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
        end
        wait_retired();
        check_state("random");

        go_idle(3);
        chk("alu_q_empty", 16'(exp_alu_q.size()), 16'd0);
        chk("res_q_empty", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
